// File: rtl/spi_pkg.sv
// Shared SPI slave types and defaults: word size, idle fill word, FSM states, edge selection.
// Pure declarations, no logic; no latency or flow control.
package spi_pkg;

  localparam int         SPI_DATA_WIDTH = 8;
  localparam logic [7:0] SPI_IDLE_WORD  = 8'hFF;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  // Sample edge is the rising edge exactly when CPOL and CPHA agree (modes 0 and 3).
  function automatic logic sample_edge_sel(input logic cpol, input logic cpha);
    return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Pin-side and host-side signals of the SPI slave shifter; slave = shifter view, master = host/pins view.
// Bundle only; no latency or flow control.
interface spi_slave_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
);
  logic                  spe_i;
  logic                  cpol_i;
  logic                  cphase_i;
  logic                  lsbfe_i;
  logic                  sclk_i;
  logic                  ss_i;
  logic                  mosi_i;
  logic                  miso_o;
  logic                  miso_oe_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_wr_i;
  logic                  tx_empty_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_full_o;
  logic                  rx_rd_i;
  logic                  overrun_o;
  logic                  ovr_clr_i;
  logic                  busy_o;

  modport slave (
    input  spe_i, cpol_i, cphase_i, lsbfe_i, sclk_i, ss_i, mosi_i,
    input  tx_data_i, tx_wr_i, rx_rd_i, ovr_clr_i,
    output miso_o, miso_oe_o, tx_empty_o, rx_data_o, rx_full_o, overrun_o, busy_o
  );

  modport master (
    output spe_i, cpol_i, cphase_i, lsbfe_i, sclk_i, ss_i, mosi_i,
    output tx_data_i, tx_wr_i, rx_rd_i, ovr_clr_i,
    input  miso_o, miso_oe_o, tx_empty_o, rx_data_o, rx_full_o, overrun_o, busy_o
  );

endinterface

// File: rtl/spi_slave_sync.sv
// Synchronises SCLK/SS/MOSI into PCLK and flags SCLK edges; optional SPI_SLAVE_GLITCH_FILTER_EN majority filter.
// Edge-to-action latency SYNC_STAGES+1 PCLK (+2 with filter); no backpressure, inputs are free-running pins.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESET_n,
  input  logic sclk_i,
  input  logic ss_i,
  input  logic mosi_i,
  output logic sclk_s,
  output logic ss_s,
  output logic mosi_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_raw;
  logic                   ss_raw;
  logic                   sclk_d;

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_i};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign sclk_raw = sclk_q[SYNC_STAGES-1];
  assign ss_raw   = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_GLITCH_FILTER_EN
  logic [1:0] sclk_h;
  logic [1:0] ss_h;
  logic       sclk_f;
  logic       ss_f;

  // A level must be seen on two of three consecutive samples before it is believed.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      sclk_h <= 2'b00;
      ss_h   <= 2'b11;
      sclk_f <= 1'b0;
      ss_f   <= 1'b1;
    end else begin
      sclk_h <= {sclk_h[0], sclk_raw};
      ss_h   <= {ss_h[0], ss_raw};
      sclk_f <= (sclk_raw & sclk_h[0]) | (sclk_raw & sclk_h[1]) | (sclk_h[0] & sclk_h[1]);
      ss_f   <= (ss_raw & ss_h[0]) | (ss_raw & ss_h[1]) | (ss_h[0] & ss_h[1]);
    end
  end

  assign sclk_s = sclk_f;
  assign ss_s   = ss_f;
`else
  assign sclk_s = sclk_raw;
  assign ss_s   = ss_raw;
`endif

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) sclk_d <= 1'b0;
    else           sclk_d <= sclk_s;
  end

  assign rise = sclk_s & ~sclk_d;
  assign fall = ~sclk_s & sclk_d;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave word engine: MOSI into rx holding register, tx buffer out on MISO (SPI_SLAVE_GLITCH_FILTER_EN optional).
// Acts SYNC_STAGES+1 PCLK after each SCLK edge; no stall path, a second unread word raises sticky overrun.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(SPI_IDLE_WORD)
) (
  input logic               PCLK,
  input logic               PRESET_n,
  spi_slave_shifter_if.slave bus
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic rise;
  logic fall;

  spi_slave_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .PCLK     (PCLK),
    .PRESET_n (PRESET_n),
    .sclk_i   (bus.sclk_i),
    .ss_i     (bus.ss_i),
    .mosi_i   (bus.mosi_i),
    .sclk_s   (sclk_s),
    .ss_s     (ss_s),
    .mosi_s   (mosi_s),
    .rise     (rise),
    .fall     (fall)
  );

  spi_state_t            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  tx_empty;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_full;
  logic                  overrun;
  logic                  miso;
  logic                  miso_oe;

  logic                  sample_edge;
  logic                  shift_edge;
  logic                  leave;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  load_bit;
  logic [DATA_WIDTH-1:0] load_rest;
  logic                  tx_bit;
  logic [DATA_WIDTH-1:0] tx_rest;
  logic [DATA_WIDTH-1:0] rx_next;

  always_comb begin
    sample_edge = (sample_edge_sel(bus.cpol_i, bus.cphase_i) == EDGE_RISE) ? rise : fall;
    shift_edge  = (sample_edge_sel(bus.cpol_i, bus.cphase_i) == EDGE_RISE) ? fall : rise;
    leave       = ss_s | ~bus.spe_i;
    word_done   = (state == ST_ACTIVE) & ~leave & sample_edge & (bit_cnt == LAST_BIT);
    load_word   = tx_empty ? IDLE_WORD : tx_buf;
    if (bus.lsbfe_i) begin
      load_bit  = load_word[0];
      load_rest = {1'b0, load_word[DATA_WIDTH-1:1]};
      tx_bit    = tx_sh[0];
      tx_rest   = {1'b0, tx_sh[DATA_WIDTH-1:1]};
      rx_next   = {mosi_s, rx_sh[DATA_WIDTH-1:1]};
    end else begin
      load_bit  = load_word[DATA_WIDTH-1];
      load_rest = {load_word[DATA_WIDTH-2:0], 1'b0};
      tx_bit    = tx_sh[DATA_WIDTH-1];
      tx_rest   = {tx_sh[DATA_WIDTH-2:0], 1'b0};
      rx_next   = {rx_sh[DATA_WIDTH-2:0], mosi_s};
    end
  end

  // tx_sh only ever holds the bits still to be driven; with CPHA=0 a load drives its first bit at once.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tx_buf   <= '0;
      tx_empty <= 1'b1;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_full  <= 1'b0;
      overrun  <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.spe_i && !ss_s) begin
            state    <= ST_ACTIVE;
            bit_cnt  <= '0;
            miso_oe  <= 1'b1;
            tx_empty <= 1'b1;
            if (!bus.cphase_i) begin
              miso  <= load_bit;
              tx_sh <= load_rest;
            end else begin
              tx_sh <= load_word;
            end
          end
        end
        ST_ACTIVE: begin
          if (leave) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              tx_empty <= 1'b1;
              if (!bus.cphase_i) begin
                miso  <= load_bit;
                tx_sh <= load_rest;
              end else begin
                tx_sh <= load_word;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (shift_edge && (bus.cphase_i || bit_cnt != '0)) begin
            miso  <= tx_bit;
            tx_sh <= tx_rest;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (word_done && (!rx_full || bus.rx_rd_i)) begin
        rx_data <= rx_next;
        rx_full <= 1'b1;
      end else if (bus.rx_rd_i) begin
        rx_full <= 1'b0;
      end

      if (word_done && rx_full && !bus.rx_rd_i) overrun <= 1'b1;
      else if (bus.ovr_clr_i)                   overrun <= 1'b0;

      // A write in the same cycle as a load still lands in the buffer and leaves it full.
      if (bus.tx_wr_i) begin
        tx_buf   <= bus.tx_data_i;
        tx_empty <= 1'b0;
      end
    end
  end

  assign bus.miso_o     = miso;
  assign bus.miso_oe_o  = miso_oe;
  assign bus.tx_empty_o = tx_empty;
  assign bus.rx_data_o  = rx_data;
  assign bus.rx_full_o  = rx_full;
  assign bus.overrun_o  = overrun;
  assign bus.busy_o     = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Drives SPI frames as a bus master in all four modes and scores MISO words and host-side flags
// against a word-level model of the tx buffer, rx holding register and overrun flag.
module tb_spi_slave_shifter;

  localparam int DW   = 8;
  localparam int SYNC = 2;

  logic PCLK = 1'b0;
  logic PRESET_n;
  always #5 PCLK = ~PCLK;

  spi_slave_shifter_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_shifter #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SYNC),
    .IDLE_WORD   (8'hFF)
  ) dut (
    .PCLK     (PCLK),
    .PRESET_n (PRESET_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference state
  logic [7:0] m_tx_buf;
  logic       m_tx_empty;
  logic [7:0] m_rx_data;
  logic       m_rx_full;
  logic       m_ovr;

  // Master configuration and per-frame data
  logic       m_cpol, m_cpha, m_lsb;
  int         m_half;
  logic [7:0] m_words [4];
  logic [7:0] m_got   [4];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic model_reset();
    m_tx_buf = 8'h00; m_tx_empty = 1'b1;
    m_rx_data = 8'h00; m_rx_full = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     bus.miso_o,     1'b0);
    check({tag, "_miso_oe"},  bus.miso_oe_o,  1'b0);
    check({tag, "_tx_empty"}, bus.tx_empty_o, 1'b1);
    check({tag, "_rx_data"},  bus.rx_data_o,  8'h00);
    check({tag, "_rx_full"},  bus.rx_full_o,  1'b0);
    check({tag, "_overrun"},  bus.overrun_o,  1'b0);
    check({tag, "_busy"},     bus.busy_o,     1'b0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rx_data"},  bus.rx_data_o,  m_rx_data);
    check({tag, "_rx_full"},  bus.rx_full_o,  m_rx_full);
    check({tag, "_overrun"},  bus.overrun_o,  m_ovr);
    check({tag, "_tx_empty"}, bus.tx_empty_o, m_tx_empty);
    check({tag, "_busy"},     bus.busy_o,     1'b0);
    check({tag, "_miso_oe"},  bus.miso_oe_o,  1'b0);
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.tx_data_i = d; bus.tx_wr_i = 1'b1;
    wait_cyc(1);
    bus.tx_wr_i = 1'b0;
    m_tx_buf = d; m_tx_empty = 1'b0;
  endtask

  task automatic rx_read();
    bus.rx_rd_i = 1'b1;
    wait_cyc(1);
    bus.rx_rd_i = 1'b0;
    m_rx_full = 1'b0;
  endtask

  task automatic ovr_clear();
    bus.ovr_clr_i = 1'b1;
    wait_cyc(1);
    bus.ovr_clr_i = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
    m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
    bus.cpol_i = cpol; bus.cphase_i = cpha; bus.lsbfe_i = lsb;
    bus.sclk_i = cpol;
    wait_cyc(10);
  endtask

  // abort_bits < 0 runs the whole frame; otherwise stop after that many bits by SS or by reset.
  task automatic do_frame(input string tag, input int nwords, input int abort_bits, input bit do_rst);
    logic [7:0] exp_tx [4];
    bit stop;
    int b;
    int pos;
    for (int k = 0; k < 4; k++) exp_tx[k] = 8'hFF;
    // One load at frame start and one after every completed word; the buffer feeds only the first.
    exp_tx[0] = m_tx_empty ? 8'hFF : m_tx_buf;
    m_tx_empty = 1'b1;
    for (int k = 0; k < 4; k++) m_got[k] = 8'h00;
    stop = 1'b0;
    b = 0;
    bus.ss_i = 1'b0;
    wait_cyc(2 * m_half);
    for (int w = 0; w < nwords; w++) begin
      for (int i = 0; i < 8; i++) begin
        if (!stop && abort_bits >= 0 && b == abort_bits) stop = 1'b1;
        if (!stop) begin
          pos = m_lsb ? i : 7 - i;
          if (!m_cpha) begin
            bus.mosi_i = m_words[w][pos];
            wait_cyc(m_half);
            m_got[w][pos] = bus.miso_o;
            bus.sclk_i = ~m_cpol;
            wait_cyc(m_half);
            bus.sclk_i = m_cpol;
          end else begin
            bus.sclk_i = ~m_cpol;
            bus.mosi_i = m_words[w][pos];
            wait_cyc(m_half);
            m_got[w][pos] = bus.miso_o;
            bus.sclk_i = m_cpol;
            wait_cyc(m_half);
          end
          b++;
        end
      end
    end
    if (!stop) begin
      wait_cyc(m_half);
      bus.ss_i = 1'b1;
      wait_cyc(10);
      for (int w = 0; w < nwords; w++) begin
        check($sformatf("%s_miso_w%0d", tag, w), m_got[w], exp_tx[w]);
        if (!m_rx_full) begin
          m_rx_data = m_words[w];
          m_rx_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
      check_model(tag);
      check({tag, "_miso_idle"}, bus.miso_o, 1'b0);
    end else if (do_rst) begin
      PRESET_n = 1'b0;
      #1;
      check_reset_outputs({tag, "_rst"});
      bus.ss_i = 1'b1; bus.sclk_i = m_cpol; bus.mosi_i = 1'b0;
      wait_cyc(3);
      PRESET_n = 1'b1;
      model_reset();
      wait_cyc(10);
    end else begin
      bus.ss_i = 1'b1;
      repeat (SYNC + 1) @(posedge PCLK);
      #1;
      check({tag, "_abort_busy"},    bus.busy_o,    1'b0);
      check({tag, "_abort_miso_oe"}, bus.miso_oe_o, 1'b0);
      check({tag, "_abort_rx_full"}, bus.rx_full_o, m_rx_full);
      wait_cyc(10);
      check_model({tag, "_abort"});
    end
  endtask

  initial begin
    bus.spe_i = 1'b1; bus.cpol_i = 1'b0; bus.cphase_i = 1'b0; bus.lsbfe_i = 1'b0;
    bus.sclk_i = 1'b0; bus.ss_i = 1'b1; bus.mosi_i = 1'b0;
    bus.tx_data_i = 8'h00; bus.tx_wr_i = 1'b0; bus.rx_rd_i = 1'b0; bus.ovr_clr_i = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; m_half = 6;
    for (int k = 0; k < 4; k++) m_words[k] = 8'h00;
    model_reset();
    PRESET_n = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    PRESET_n = 1'b1;
    wait_cyc(5);

    set_mode(1'b0, 1'b0, 1'b0);
    tx_write(8'hA5);
    m_words[0] = 8'h3C;
    do_frame("mode0_msb", 1, -1, 1'b0);
    rx_read();

    set_mode(1'b1, 1'b1, 1'b1);
    tx_write(8'h81);
    m_words[0] = 8'h01;
    do_frame("mode3_lsb", 1, -1, 1'b0);
    rx_read();

    set_mode(1'b0, 1'b0, 1'b0);
    m_words[0] = 8'h11; m_words[1] = 8'h22;
    do_frame("overrun", 2, -1, 1'b0);
    ovr_clear();
    check("ovr_clr", bus.overrun_o, m_ovr);
    rx_read();

    set_mode(1'b0, 1'b1, 1'b0);
    m_words[0] = 8'($urandom);
    do_frame("mode1_empty", 1, -1, 1'b0);
    rx_read();

    set_mode(1'b0, 1'b0, 1'b0);
    tx_write(8'h5A);
    m_words[0] = 8'hC3;
    do_frame("ss_abort", 1, 5, 1'b0);
    m_words[0] = 8'h96;
    do_frame("after_abort", 1, -1, 1'b0);
    rx_read();

    tx_write(8'h77);
    m_words[0] = 8'hD2;
    do_frame("mid_reset", 1, 3, 1'b1);
    tx_write(8'hE7);
    m_words[0] = 8'h4B;
    do_frame("after_reset", 1, -1, 1'b0);
    rx_read();

    for (int r = 0; r < 20; r++) begin
      set_mode(1'($urandom), 1'($urandom), 1'($urandom));
      m_half = $urandom_range(8, 6);
      if ($urandom_range(1, 0) == 1) tx_write(8'($urandom));
      if ($urandom_range(1, 0) == 1) rx_read();
      if ($urandom_range(3, 0) == 0) ovr_clear();
      for (int k = 0; k < 4; k++) m_words[k] = 8'($urandom);
      do_frame($sformatf("rand%0d", r), $urandom_range(3, 1), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
